systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 14 +
 rtl/systolic_feeder_skew_mux.sv | 27 ++
 rtl/systolic_feeder.sv | 111 +++++++++++
 3 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the 3x3 systolic array operand feeder.
package systolic_feeder_pkg;
    localparam int N         = 3;
    localparam int FEED_CYC  = 5;
    localparam int DRAIN_CYC = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/systolic_feeder_skew_mux.sv
// Picks the skewed operand for one array edge lane at feed step t, or 0 outside the wavefront.
module systolic_skew_mux
    import systolic_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANE       = 0,
    parameter bit COL_MAJOR  = 1'b0
) (
    input  logic [N*N*DATA_WIDTH-1:0] mat,
    input  logic [2:0]                t,
    input  logic                      en,
    output logic [DATA_WIDTH-1:0]     op
);
    int k;
    int idx;

    // Row lanes walk A[lane][t-lane]; column lanes walk B[t-lane][lane].
    always_comb begin
        op  = '0;
        k   = int'(t) - LANE;
        idx = 0;
        if (en && k >= 0 && k < N) begin
            idx = COL_MAJOR ? (k * N + LANE) : (LANE * N + k);
            op  = mat[idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// Sequences one 3x3 matmul job: clear accumulators, stream skewed operands, drain, signal done.
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] a_mat,
    input  logic [9*DATA_WIDTH-1:0] b_mat,
    output logic [DATA_WIDTH-1:0]   a1,
    output logic [DATA_WIDTH-1:0]   a2,
    output logic [DATA_WIDTH-1:0]   a3,
    output logic [DATA_WIDTH-1:0]   b1,
    output logic [DATA_WIDTH-1:0]   b2,
    output logic [DATA_WIDTH-1:0]   b3,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done
);
    import systolic_feeder_pkg::*;

    state_t                       state, nxt;
    logic [2:0]                   cnt, cnt_nxt;
    logic                         ready_q;
    logic                         accept;
    logic                         feed;
    logic [9*DATA_WIDTH-1:0]      a_q, b_q;
    logic [N-1:0][DATA_WIDTH-1:0] a_lane, b_lane;

    // ready_q keeps in_ready low while reset is held, rising on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            ready_q <= 1'b1;
            if (accept) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
        end
    end

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        in_ready = 1'b0;
        accept   = 1'b0;
        acc_clr  = 1'b0;
        feed     = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = ready_q;
                accept   = in_valid && ready_q;
                if (accept) nxt = CLEAR;
            end
            CLEAR: begin
                acc_clr = 1'b1;
                cnt_nxt = '0;
                nxt     = FEED;
            end
            FEED: begin
                feed = 1'b1;
                if (cnt == 3'(FEED_CYC - 1)) begin
                    cnt_nxt = '0;
                    nxt     = DRAIN;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DRAIN: begin
                if (cnt == 3'(DRAIN_CYC - 1)) begin
                    cnt_nxt = '0;
                    nxt     = DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_skew_mux #(.DATA_WIDTH(DATA_WIDTH), .LANE(i), .COL_MAJOR(1'b0)) u_a (
            .mat(a_q), .t(cnt), .en(feed), .op(a_lane[i])
        );
        systolic_skew_mux #(.DATA_WIDTH(DATA_WIDTH), .LANE(i), .COL_MAJOR(1'b1)) u_b (
            .mat(b_q), .t(cnt), .en(feed), .op(b_lane[i])
        );
    end

    assign a1 = a_lane[0];
    assign a2 = a_lane[1];
    assign a3 = a_lane[2];
    assign b1 = b_lane[0];
    assign b2 = b_lane[1];
    assign b3 = b_lane[2];
endmodule
